// File: rtl/addr_seq_ctrl.sv
// Address-sequencing controller: drives an external loadable counter across a burst
// range, strobes each address to memory and checks the counter against its own copy.
module addr_seq_ctrl #(
  parameter int AW = 8,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_start,
  input  logic [LW-1:0] cmd_len,
  input  logic          stall,
  input  logic          abort,
  input  logic [AW-1:0] CNT,
  output logic          load,
  output logic [AW-1:0] CNT_In,
  output logic          EN,
  output logic          acc_valid,
  output logic          acc_last,
  output logic          busy,
  output logic          done,
  output logic          addr_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);
  localparam logic [LW-1:0] ONE_LEN = LW'(1);

  state_t        state;
  logic [AW-1:0] start_q;
  logic [AW-1:0] exp_q;
  logic [LW-1:0] rem_q;
  logic          beat;
  logic          last;

  // A beat needs RUN with the memory side ready; abort outranks both stall and the last beat.
  assign beat      = (state == RUN) && !stall && !abort;
  assign last      = (rem_q == ONE_LEN);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign load      = (state == LOAD) && !abort;
  assign CNT_In    = start_q;
  assign EN        = beat && !last;
  assign acc_valid = beat;
  assign acc_last  = beat && last;

  // EN is withheld on the final beat so the counter parks on the last address.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      start_q  <= '0;
      rem_q    <= '0;
      exp_q    <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_q  <= cmd_start;
            rem_q    <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            addr_err <= 1'b0;
            state    <= (cmd_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            exp_q <= start_q;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!stall) begin
            rem_q <= rem_q - ONE_LEN;
            exp_q <= exp_q + AW'(1);
            if (CNT != exp_q) addr_err <= 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl: a behavioural 8-bit counter closes the loop and
// each burst is predicted from its start/length as an address sequence plus timing rules.
module tb_addr_seq_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = '0;
  logic [8:0] cmd_len = '0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] CNT;
  logic       load;
  logic [7:0] CNT_In;
  logic       EN;
  logic       acc_valid;
  logic       acc_last;
  logic       busy;
  logic       done;
  logic       addr_err;

  logic [7:0] cntReg;
  logic       forceOn = 1'b0;
  int         checks = 0;
  int         errors = 0;

  addr_seq_ctrl #(.AW(8), .LW(9)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .stall(stall), .abort(abort),
    .CNT(CNT), .load(load), .CNT_In(CNT_In), .EN(EN), .acc_valid(acc_valid),
    .acc_last(acc_last), .busy(busy), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // The counter being sequenced; forceOn lets a beat present a wrong address.
  always @(posedge clk or negedge res) begin
    if (!res) cntReg <= '0;
    else if (load) cntReg <= CNT_In;
    else if (EN) cntReg <= cntReg + 8'd1;
  end
  assign CNT = forceOn ? 8'h55 : cntReg;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge while the DUT is idle; returns just after a falling edge.
  task automatic applyStimulus(input logic [7:0] start, input int len, input int stallPct,
                               input int abortAt, input int forceBeat);
    int         effLen;
    int         k;
    int         guard;
    bit         st;
    bit         ab;
    bit         expV;
    bit         aborted;
    bit         errExp;
    logic [7:0] expA;
    effLen  = (len > 256) ? 256 : len;
    k       = 0;
    guard   = 0;
    aborted = 1'b0;
    errExp  = 1'b0;
    cmd_valid = 1'b1;
    cmd_start = start;
    cmd_len   = 9'(len);
    checkOutput("accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_len   = 9'($urandom_range(0, 511));
    @(negedge clk);
    checkOutput("clear_err", addr_err, 0);
    checkOutput("busy_c1", busy, 1);
    if (effLen == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_load", load, 0);
      checkOutput("zero_en", EN, 0);
      checkOutput("zero_valid", acc_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("zero_done_end", done, 0);
      checkOutput("zero_ready", cmd_ready, 1);
      return;
    end
    checkOutput("load_pulse", load, 1);
    checkOutput("load_value", CNT_In, start);
    checkOutput("load_en", EN, 0);
    checkOutput("load_valid", acc_valid, 0);
    checkOutput("load_ready", cmd_ready, 0);
    @(posedge clk); #1;
    while (k < effLen && !aborted && guard < 3000) begin
      st = (k != forceBeat) && ($urandom_range(0, 99) < stallPct);
      ab = (k == abortAt);
      stall   = st;
      abort   = ab;
      forceOn = (k == forceBeat) && !ab;
      expV = !st && !ab;
      expA = 8'(start + 8'(k));
      @(negedge clk);
      checkOutput("acc_valid", acc_valid, expV);
      checkOutput("acc_last", acc_last, expV && (k == effLen - 1));
      checkOutput("en", EN, expV && (k != effLen - 1));
      checkOutput("run_load", load, 0);
      checkOutput("run_done", done, 0);
      if (expV && forceOn) errExp = (expA != 8'h55);
      else if (expV) checkOutput("beat_addr", CNT, expA);
      if (ab) aborted = 1'b1;
      else if (expV) k++;
      @(posedge clk); #1;
      stall   = 1'b0;
      abort   = 1'b0;
      forceOn = 1'b0;
      guard++;
    end
    if (guard >= 3000) checkOutput("run_timeout", 1, 0);
    @(negedge clk);
    if (aborted) begin
      checkOutput("abort_idle", cmd_ready, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_nodone", done, 0);
    end else begin
      checkOutput("done_pulse", done, 1);
      checkOutput("done_ready", cmd_ready, 0);
      checkOutput("final_cnt", CNT, 8'(start + 8'(effLen - 1)));
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("done_end", done, 0);
      checkOutput("ready_again", cmd_ready, 1);
    end
    checkOutput("addr_err", addr_err, errExp);
  endtask

  initial begin
    int l;
    int a;
    #1;
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_cnt_in", CNT_In, 0);
    checkOutput("rst_load", load, 0);
    checkOutput("rst_en", EN, 0);
    checkOutput("rst_valid", acc_valid, 0);
    checkOutput("rst_last", acc_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", addr_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);

    applyStimulus(8'h10, 4, 0, -1, -1);
    applyStimulus(8'h20, 3, 40, -1, -1);
    applyStimulus(8'hFE, 4, 0, -1, -1);
    applyStimulus(8'h00, 256, 0, -1, -1);
    applyStimulus(8'h33, 0, 0, -1, -1);
    applyStimulus(8'h80, 300, 20, -1, -1);
    applyStimulus(8'h40, 8, 0, 2, -1);
    applyStimulus(8'h41, 2, 0, -1, -1);
    applyStimulus(8'h50, 4, 0, -1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("err_sticky", addr_err, 1);
    applyStimulus(8'h60, 2, 0, -1, -1);

    for (int i = 0; i < 15; i++) begin
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 511)) : int'($urandom_range(0, 30));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
      applyStimulus(8'($urandom_range(0, 255)), l, 25, a, -1);
    end

    // Reset arriving in the middle of a sweep.
    cmd_valid = 1'b1;
    cmd_start = 8'h30;
    cmd_len   = 9'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    res = 1'b0;
    #1;
    checkOutput("mid_rst_ready", cmd_ready, 1);
    checkOutput("mid_rst_cnt_in", CNT_In, 0);
    checkOutput("mid_rst_load", load, 0);
    checkOutput("mid_rst_en", EN, 0);
    checkOutput("mid_rst_valid", acc_valid, 0);
    checkOutput("mid_rst_last", acc_last, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_seq_ctrl.md
# addr_seq_ctrl

Address-sequencing controller directly upstream of the 8-bit loadable counter in the memory unit. It accepts burst commands (start address, length) over a valid/ready handshake. It drives the counter's `load`, `CNT_In` and `EN` inputs so that the counter sweeps the requested address range. It emits one access strobe per address to the memory side, checks the returned count against its own expected address, and pulses `done` at burst end.

## Interface

Parameters:
- `AW`, 8, address / counter width.
- `LW`, 9, burst-length width (AW+1, so a full 2^AW burst is expressible).

Ports:
- `clk` input 1: single clock, rising edge.
- `res` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command.
- `cmd_start` input AW: first address of the burst.
- `cmd_len` input LW: number of addresses to visit (0 allowed).
- `stall` input 1: memory side not ready; freezes the sweep.
- `abort` input 1: terminate the current burst.
- `CNT` input AW: counter output, fed back.
- `load` output 1: to the counter; loads `CNT_In`.
- `CNT_In` output AW: to the counter; load value.
- `EN` output 1: to the counter; increment enable.
- `acc_valid` output 1: `CNT` is a valid burst address this cycle.
- `acc_last` output 1: the current `acc_valid` beat is the final one.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at normal burst completion.
- `addr_err` output 1: sticky flag, set on a `CNT` mismatch during a beat.

## Operation

- **States:** IDLE, LOAD, RUN, DONE.
- **Registers:** `start_q` (AW), `rem_q` (LW), `exp_q` (AW), `addr_err`.

**IDLE**
- `cmd_ready`=1.
- On `cmd_valid`: capture `start_q`←`cmd_start`, `rem_q`←`cmd_len`.
- If `cmd_len`==0, go to DONE. Otherwise go to LOAD.

**LOAD**
- `load`=1 and `CNT_In`=`start_q` for exactly one cycle.
- `exp_q`←`start_q`, then go to RUN.

**RUN**
- `acc_valid`=!`stall`.
- `acc_last`=`acc_valid` && (`rem_q`==1).
- On each beat:
  - `rem_q` decrements and `exp_q` increments mod 2^AW.
  - `EN`=1, except on the last beat, where `EN`=0. The counter therefore stays at the final address.
- A beat with `rem_q`==1 goes to DONE.
- While `stall`=1: `EN`=0, `acc_valid`=0, and all registers hold.

**DONE**
- `done`=1 for one cycle, then go to IDLE.

**Outputs outside RUN/LOAD:** `load`, `EN`, `acc_valid` and `acc_last` are 0, and `CNT_In`=`start_q`.

**Address check**
- Any beat with `CNT`≠`exp_q` sets `addr_err`.
- `addr_err` is cleared only by reset or by command acceptance.

**Abort**
- `abort` in LOAD or RUN forces the next state to IDLE. No `done` pulse is produced.
- `acc_valid`, `EN` and `load` are forced to 0 in the abort cycle.
- `abort` in IDLE or DONE is ignored.
- `abort` has priority over `stall` and over a last beat in the same cycle.

**Wrap-around:** an address sweep past 2^AW−1 wraps to 0. `exp_q` wraps identically, so the wrap raises no error.

**Width rules:** `cmd_len` up to 2^AW is legal. Values above 2^AW are clamped to 2^AW at capture.

## Timing

**Reset (asynchronous)**
- State=IDLE.
- `start_q`, `rem_q`, `exp_q` and `addr_err` = 0.
- Outputs:
  - `cmd_ready`=1
  - `CNT_In`=0
  - `load`, `EN`, `acc_valid`, `acc_last`, `busy`, `done` = 0
- Reset mid-burst discards the burst; no `done` is produced.

**Burst timing**
- Command accepted at edge E0.
- LOAD occupies cycle 1 and the counter loads at edge E2.
- RUN starts in cycle 2 with `CNT`=start.
- With no stalls, beats occupy cycles 2..len+1, DONE is in cycle len+2, and `cmd_ready` is 1 again in cycle len+3.
- Each stall cycle adds one cycle.
- `len`=0: DONE in cycle 1, no `load`, no beats.

**Control timing**
- `cmd_ready` is a function of the registered state only.
- `EN` and `load` are never both 1.

## Test plan

- **Basic burst:** start=0x10, len=4, no stall → `load` in cycle 1; beats with `CNT`=0x10,0x11,0x12,0x13; `acc_last` on 0x13; `done` in cycle 6; `CNT` holds 0x13; `addr_err`=0.
- **Stall:** start=0x20, len=3, `stall` high on cycles 3–4 → addresses 0x20,0x21,0x22 each appear exactly once with `acc_valid`; `done` is delayed by 2 cycles.
- **Wrap and full length:** start=0xFE, len=4 → beats on 0xFE,0xFF,0x00,0x01 with no error. len=256, start=0 → 256 beats, `done`, final `CNT`=0xFF.
- **Zero length:** len=0 → `done` pulse one cycle after acceptance; `load` and `EN` never asserted.
- **Abort:** start=0x40, len=8, `abort` on the 3rd beat cycle → 2 beats delivered; `acc_valid`=0 in the abort cycle; IDLE next cycle; no `done`. A new command is accepted in the following cycle.
- **Address check and reset:** force `CNT`=0x55 while 0x50 is expected → `addr_err` sets and stays set until the next command. Assert `res` mid-RUN → all outputs go to their reset values immediately.
